tc_boot_loader: RTL

Boot-time controller for the tiny computer. It holds the CPU in reset and accepts a byte stream over a valid/ready handshake. It packs the bytes into 32-bit words and writes them into consecutive instruction-memory locations through the IM write port. Once the image is complete, and verified when the checksum option is enabled, it releases the CPU to start executing at address 0.

---
 rtl/tc_boot_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tc_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit IM words, then releases the CPU.
// Optional trailing XOR checksum byte is compiled in with `define BOOT_CHECKSUM_EN.
`timescale 1ns/1ps
module tc_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              Ph0,
  input  logic              Reset,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              ImWe,
  output logic [ADDR_W-1:0] ImAddr,
  output logic [DATA_W-1:0] ImData,
  output logic              CpuReset,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT_LO = 3'd1,
    COUNT_HI = 3'd2,
    DATA     = 3'd3,
    FLUSH    = 3'd4,
    RUN      = 3'd5,
    ERROR    = 3'd6
`ifdef BOOT_CHECKSUM_EN
    , CHECK  = 3'd7
`endif
  } state_e;

  localparam logic [16:0]     MaxWords = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] OneWord  = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [7:0]          countLo_q, countLo_d;
  logic [ADDR_W:0]     wordCnt_q, wordCnt_d;
  logic [ADDR_W:0]     wordIdx_q, wordIdx_d;
  logic [1:0]          byteIdx_q, byteIdx_d;
  logic [23:0]         shift_q, shift_d;
  logic                imWe_q, imWe_d;
  logic [ADDR_W-1:0]   imAddr_q, imAddr_d;
  logic [DATA_W-1:0]   imData_q, imData_d;
  logic                cpuReset_q, cpuReset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic        accept;
  logic [15:0] countFull;
  logic        countOk;
  logic        lastWord;

  assign accept    = ByteValid & ByteReady;
  assign countFull = {ByteIn, countLo_q};
  assign countOk   = (countFull != 16'd0) && ({1'b0, countFull} <= MaxWords);
  assign lastWord  = (wordIdx_q == (wordCnt_q - OneWord));

  always_ff @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      countLo_q  <= '0;
      wordCnt_q  <= '0;
      wordIdx_q  <= '0;
      byteIdx_q  <= '0;
      shift_q    <= '0;
      imWe_q     <= 1'b0;
      imAddr_q   <= '0;
      imData_q   <= '0;
      cpuReset_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      countLo_q  <= countLo_d;
      wordCnt_q  <= wordCnt_d;
      wordIdx_q  <= wordIdx_d;
      byteIdx_q  <= byteIdx_d;
      shift_q    <= shift_d;
      imWe_q     <= imWe_d;
      imAddr_q   <= imAddr_d;
      imData_q   <= imData_d;
      cpuReset_q <= cpuReset_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef BOOT_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  // Bytes shift in from the top so byte k of a word ends up at bits 8k+7:8k.
  always_comb begin
    state_d   = state_q;
    countLo_d = countLo_q;
    wordCnt_d = wordCnt_q;
    wordIdx_d = wordIdx_q;
    byteIdx_d = byteIdx_q;
    shift_d   = shift_q;
    imWe_d    = 1'b0;
    imAddr_d  = imAddr_q;
    imData_d  = imData_q;
`ifdef BOOT_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      IDLE: state_d = COUNT_LO;
      COUNT_LO: begin
        if (accept) begin
          countLo_d = ByteIn;
          state_d   = COUNT_HI;
        end
      end
      COUNT_HI: begin
        if (accept) begin
          if (countOk) begin
            wordCnt_d = (ADDR_W+1)'(countFull);
            state_d   = DATA;
          end else begin
            state_d   = ERROR;
          end
        end
      end
      DATA: begin
        if (accept) begin
          shift_d   = {ByteIn, shift_q[23:8]};
          byteIdx_d = byteIdx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          xor_d     = xor_q ^ ByteIn;
`endif
          if (byteIdx_q == 2'd3) begin
            imWe_d    = 1'b1;
            imAddr_d  = wordIdx_q[ADDR_W-1:0];
            imData_d  = {ByteIn, shift_q};
            wordIdx_d = wordIdx_q + OneWord;
            if (lastWord) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = FLUSH;
`endif
            end
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_d = (ByteIn == xor_q) ? RUN : ERROR;
        end
      end
`endif
      FLUSH: state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  // Status flags follow the next state so they switch on the same edge that enters RUN/ERROR.
  always_comb begin
    ByteReady  = 1'b0;
    cpuReset_d = (state_d != RUN);
    done_d     = (state_d == RUN);
    error_d    = (state_d == ERROR);
    case (state_q)
      COUNT_LO, COUNT_HI, DATA: ByteReady = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      CHECK: ByteReady = 1'b1;
`endif
      default: ByteReady = 1'b0;
    endcase
  end

  assign ImWe     = imWe_q;
  assign ImAddr   = imAddr_q;
  assign ImData   = imData_q;
  assign CpuReset = cpuReset_q;
  assign Done     = done_q;
  assign Error    = error_q;

endmodule
